lsu_mem_stage: RTL and testbench

Load/store unit for the RV32I memory stage, sitting between the execute stage and the byte-addressed data memory.
- Accepts one memory request per handshake and checks alignment, range and funct3.
- Drives the data memory ports and returns a register-writeback response.
- Issues every load as an aligned word read and performs lane extraction and sign/zero extension itself.
- Splits halfword stores at byte offset 2 into two byte stores, because the memory forms halfword byte addresses from addr[8:2].

---
 rtl/lsu_mem_stage.sv | 200 ++++++++++++++++++++
 tb/tb_lsu_mem_stage.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_stage.sv
// RV32I memory-stage load/store unit.
// Word-read loads with local extension; split SH at byte offset 2.
module lsu_mem_stage #(
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_load,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [4:0]        req_rd,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_data,
  output logic [4:0]        rsp_rd,
  output logic              rsp_we,
  output logic              rsp_fault,
  output logic              mem_read,
  output logic              mem_write,
  output logic [2:0]        mem_funct3,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_write_val,
  input  logic [31:0]       mem_read_val
);

  typedef enum logic [1:0] {
    IDLE, ACC, ACC2, RESP
  } state_t;

  state_t            r_state;
  logic              r_load;
  logic              r_split;
  logic [2:0]        r_f3;
  logic [1:0]        r_off;
  logic [7:0]        r_hi;
  logic [ADDR_W-1:0] r_addr;

  logic        w_both;
  logic        w_any;
  logic        w_range;
  logic        w_f3bad;
  logic        w_mis;
  logic        w_fault;
  logic        w_split;
  logic [31:0] w_lane;
  logic [31:0] w_ext;

  // Request legality and split-halfword detection.
  always_comb begin
    w_both  = req_load && req_store;
    w_any   = req_load || req_store;
    w_range = |req_addr[31:ADDR_W];
    w_f3bad = req_load
            ? (req_funct3 == 3'b011 ||
               req_funct3[2:1] == 2'b11)
            : (req_funct3 > 3'b010);
    w_mis = 1'b0;
    unique case (1'b1)
      req_funct3[1:0] == 2'b01:
        w_mis = req_addr[0];
      req_funct3[1:0] == 2'b10:
        w_mis = |req_addr[1:0];
      default:
        w_mis = 1'b0;
    endcase
    w_fault = w_both ||
              (w_any && (w_range || w_f3bad || w_mis));
    w_split = req_store && !w_fault &&
              req_funct3 == 3'b001 && req_addr[1];
  end

  // Lane select and extension of the word read.
  always_comb begin
    w_lane = mem_read_val >> {r_off, 3'b000};
    w_ext  = mem_read_val;
    unique case (1'b1)
      r_f3 == 3'b000:
        w_ext = {{24{w_lane[7]}}, w_lane[7:0]};
      r_f3 == 3'b001:
        w_ext = {{16{w_lane[15]}}, w_lane[15:0]};
      r_f3 == 3'b100:
        w_ext = {24'b0, w_lane[7:0]};
      r_f3 == 3'b101:
        w_ext = {16'b0, w_lane[15:0]};
      default:
        w_ext = mem_read_val;
    endcase
  end

  // Control FSM with registered memory and response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      req_ready     <= 1'b1;
      rsp_valid     <= 1'b0;
      rsp_data      <= '0;
      rsp_rd        <= '0;
      rsp_we        <= 1'b0;
      rsp_fault     <= 1'b0;
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      mem_funct3    <= '0;
      mem_addr      <= '0;
      mem_write_val <= '0;
      r_load        <= 1'b0;
      r_split       <= 1'b0;
      r_f3          <= '0;
      r_off         <= '0;
      r_hi          <= '0;
      r_addr        <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_load    <= req_load;
            r_split   <= w_split;
            r_f3      <= req_funct3;
            r_off     <= req_addr[1:0];
            r_hi      <= req_wdata[15:8];
            r_addr    <= req_addr[ADDR_W-1:0];
            req_ready <= 1'b0;
            rsp_rd    <= req_rd;
            rsp_data  <= '0;
            rsp_we    <= 1'b0;
            if (w_fault || !w_any) begin
              r_state   <= RESP;
              rsp_valid <= 1'b1;
              rsp_fault <= w_fault;
            end else begin
              r_state   <= ACC;
              rsp_fault <= 1'b0;
              mem_read  <= req_load;
              mem_write <= req_store;
              if (req_load) begin
                mem_funct3    <= 3'b010;
                mem_addr      <= {req_addr[ADDR_W-1:2],
                                  2'b00};
                mem_write_val <= '0;
              end else begin
                mem_funct3    <= w_split ? 3'b000
                                         : req_funct3;
                mem_addr      <= req_addr[ADDR_W-1:0];
                mem_write_val <= w_split
                  ? {24'b0, req_wdata[7:0]}
                  : req_wdata;
              end
            end
          end
        end
        ACC: begin
          if (r_load) begin
            rsp_data <= w_ext;
            rsp_we   <= (rsp_rd != 5'd0);
          end
          if (r_split) begin
            r_state       <= ACC2;
            mem_read      <= 1'b0;
            mem_write     <= 1'b1;
            mem_funct3    <= 3'b000;
            mem_addr      <= r_addr + ADDR_W'(1);
            mem_write_val <= {24'b0, r_hi};
          end else begin
            r_state       <= RESP;
            rsp_valid     <= 1'b1;
            mem_read      <= 1'b0;
            mem_write     <= 1'b0;
            mem_funct3    <= '0;
            mem_addr      <= '0;
            mem_write_val <= '0;
          end
        end
        ACC2: begin
          r_state       <= RESP;
          rsp_valid     <= 1'b1;
          mem_write     <= 1'b0;
          mem_funct3    <= '0;
          mem_addr      <= '0;
          mem_write_val <= '0;
        end
        RESP: begin
          if (rsp_ready) begin
            r_state   <= IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_rd    <= '0;
            rsp_we    <= 1'b0;
            rsp_fault <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Bench for lsu_mem_stage: byte-array memory, reference
// model of the memory image, directed request table.
module tb_lsu_mem_stage;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_load;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [4:0]  rsp_rd;
  logic        rsp_we;
  logic        rsp_fault;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  mem_funct3;
  logic [8:0]  mem_addr;
  logic [31:0] mem_write_val;
  logic [31:0] mem_read_val;

  int errs = 0;
  int checks = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;

  logic [7:0] dmem [512] = '{default: 8'h00};
  logic [7:0] refm [512] = '{default: 8'h00};

  logic [31:0] exp_data;
  logic [4:0]  exp_rd;
  logic        exp_we;
  logic        exp_fault;
  int          exp_rdc;
  int          exp_wrc;

  lsu_mem_stage #(.ADDR_W(9)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_load(req_load), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_rd(req_rd),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_rd(rsp_rd),
    .rsp_we(rsp_we), .rsp_fault(rsp_fault),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_funct3(mem_funct3), .mem_addr(mem_addr),
    .mem_write_val(mem_write_val),
    .mem_read_val(mem_read_val)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Data memory: word reads; halfwords use addr[8:2] only.
  assign mem_read_val = {dmem[{mem_addr[8:2], 2'd3}],
                         dmem[{mem_addr[8:2], 2'd2}],
                         dmem[{mem_addr[8:2], 2'd1}],
                         dmem[{mem_addr[8:2], 2'd0}]};

  always @(posedge clk) begin
    if (rst_n && mem_write) begin
      case (mem_funct3)
        3'b000: dmem[mem_addr] <= mem_write_val[7:0];
        3'b001: begin
          dmem[{mem_addr[8:2], 2'd0}] <= mem_write_val[7:0];
          dmem[{mem_addr[8:2], 2'd1}] <= mem_write_val[15:8];
        end
        default: begin
          dmem[{mem_addr[8:2], 2'd0}] <= mem_write_val[7:0];
          dmem[{mem_addr[8:2], 2'd1}] <= mem_write_val[15:8];
          dmem[{mem_addr[8:2], 2'd2}] <= mem_write_val[23:16];
          dmem[{mem_addr[8:2], 2'd3}] <= mem_write_val[31:24];
        end
      endcase
    end
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Compare process: response vs model, idle memory bus.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_read) rd_cnt++;
      if (mem_write) wr_cnt++;
      if (rsp_valid) begin
        chk("rsp_data", rsp_data, exp_data);
        chk("rsp_rd", 32'(rsp_rd), 32'(exp_rd));
        chk("rsp_we", 32'(rsp_we), 32'(exp_we));
        chk("rsp_fault", 32'(rsp_fault), 32'(exp_fault));
        chk("ready_busy", 32'(req_ready), 0);
      end
      if (!mem_read && !mem_write)
        chk("mem_idle", mem_write_val | 32'(mem_addr)
            | 32'(mem_funct3), 0);
    end
  end

  // Reference: what a request must do to the byte image.
  task automatic model(input logic ld, input logic st,
                       input logic [2:0] f3,
                       input logic [31:0] a,
                       input logic [31:0] wd,
                       input logic [4:0] rd);
    int sz;
    bit bad;
    logic [31:0] v;
    sz = 1 << f3[1:0];
    bad = (ld && st) ||
          ((ld || st) &&
           (a >= 32'd512 ||
            (ld && (f3 == 3 || f3 == 6 || f3 == 7)) ||
            (st && f3 > 2) ||
            (a % sz != 0)));
    exp_fault = bad;
    exp_rd = rd;
    exp_data = 0;
    exp_we = 0;
    exp_rdc = 0;
    exp_wrc = 0;
    if (!bad && ld) begin
      v = 0;
      for (int i = 0; i < sz; i++)
        v = v | (32'(refm[a + i]) << (8 * i));
      if (!f3[2] && sz == 1) v = {{24{v[7]}}, v[7:0]};
      if (!f3[2] && sz == 2) v = {{16{v[15]}}, v[15:0]};
      exp_data = v;
      exp_we = (rd != 0);
      exp_rdc = 1;
    end
    if (!bad && st) begin
      for (int i = 0; i < sz; i++)
        refm[a + i] = wd[8 * i +: 8];
      exp_wrc = (f3 == 1 && a[1]) ? 2 : 1;
    end
  endtask

  task automatic xact(input logic ld, input logic st,
                      input logic [2:0] f3,
                      input logic [31:0] a,
                      input logic [31:0] wd,
                      input logic [4:0] rd,
                      input int lat, input bit lchk,
                      input logic [31:0] lit,
                      input int hold);
    int n;
    logic [31:0] held;
    n = 0;
    while (!req_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk("req_ready", 32'(req_ready), 1);
    req_valid = 1; req_load = ld; req_store = st;
    req_funct3 = f3; req_addr = a;
    req_wdata = wd; req_rd = rd;
    @(posedge clk);
    model(ld, st, f3, a, wd, rd);
    #1;
    req_valid = 0; req_load = 0; req_store = 0;
    rd_cnt = 0; wr_cnt = 0;
    n = 1;
    while (!rsp_valid && n < 10) begin
      @(posedge clk); #1; n++;
    end
    chk("latency", n, lat);
    if (lchk) chk("literal", rsp_data, lit);
    held = rsp_data;
    for (int i = 0; i < hold; i++) begin
      if (i == 1) begin
        req_valid = 1; req_store = 1; req_funct3 = 3'b010;
        req_addr = 32'h40; req_wdata = 32'hFFFF_FFFF;
      end
      @(posedge clk); #1;
      chk("hold_valid", 32'(rsp_valid), 1);
      chk("hold_data", rsp_data, held);
      chk("hold_ready", 32'(req_ready), 0);
    end
    req_valid = 0; req_store = 0;
    chk("rd_pulses", rd_cnt, exp_rdc);
    chk("wr_pulses", wr_cnt, exp_wrc);
    rsp_ready = 1;
    @(posedge clk); #1;
    rsp_ready = 0;
    chk("rsp_drop", 32'(rsp_valid), 0);
  endtask

  task automatic chk_reset_outs();
    chk("rst_req_ready", 32'(req_ready), 1);
    chk("rst_rsp", 32'(rsp_valid) | rsp_data
        | 32'(rsp_rd) | 32'(rsp_we) | 32'(rsp_fault), 0);
    chk("rst_mem", 32'(mem_read) | 32'(mem_write)
        | 32'(mem_funct3) | 32'(mem_addr)
        | mem_write_val, 0);
  endtask

  initial begin
    int nbad;
    rst_n = 0; req_valid = 0; req_load = 0;
    req_store = 0; req_funct3 = 0; req_addr = 0;
    req_wdata = 0; req_rd = 0; rsp_ready = 0;
    exp_data = 0; exp_rd = 0; exp_we = 0;
    exp_fault = 0; exp_rdc = 0; exp_wrc = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outs();
    rst_n = 1;
    @(posedge clk); #1;

    // ld st f3 addr wdata rd lat lchk literal hold
    xact(0, 1, 3'b010, 32'h10, 32'hDEADBEEF, 0, 2, 0, 0, 0);
    xact(1, 0, 3'b010, 32'h10, 0, 5, 2, 1, 32'hDEADBEEF, 0);
    xact(1, 0, 3'b000, 32'h13, 0, 6, 2, 1, 32'hFFFFFFDE, 0);
    xact(1, 0, 3'b100, 32'h13, 0, 7, 2, 1, 32'h000000DE, 0);
    xact(1, 0, 3'b001, 32'h12, 0, 8, 2, 1, 32'hFFFFDEAD, 0);
    xact(1, 0, 3'b101, 32'h10, 0, 9, 2, 1, 32'h0000BEEF, 0);
    xact(0, 1, 3'b001, 32'h16, 32'h1234, 0, 3, 0, 0, 0);
    xact(1, 0, 3'b010, 32'h14, 0, 10, 2, 1, 32'h12340000, 0);
    xact(0, 1, 3'b000, 32'h18, 32'hAABBCCDD, 0, 2, 0, 0, 0);
    xact(1, 0, 3'b000, 32'h18, 0, 11, 2, 1, 32'hFFFFFFDD, 0);
    xact(0, 1, 3'b001, 32'h1C, 32'h0000BEEF, 0, 2, 0, 0, 0);
    xact(1, 0, 3'b101, 32'h1C, 0, 12, 2, 1, 32'h0000BEEF, 0);
    xact(1, 0, 3'b010, 32'h11, 0, 13, 1, 0, 0, 0);
    xact(0, 1, 3'b001, 32'h21, 32'h5555, 0, 1, 0, 0, 0);
    xact(1, 0, 3'b010, 32'h200, 0, 14, 1, 0, 0, 0);
    xact(1, 0, 3'b011, 32'h10, 0, 15, 1, 0, 0, 0);
    xact(0, 1, 3'b011, 32'h10, 32'h1, 0, 1, 0, 0, 0);
    xact(1, 1, 3'b010, 32'h10, 0, 16, 1, 0, 0, 0);
    xact(0, 0, 3'b010, 32'h10, 0, 17, 1, 1, 32'h0, 0);
    xact(1, 0, 3'b010, 32'h10, 0, 18, 2, 1, 32'hDEADBEEF, 5);
    xact(1, 0, 3'b010, 32'h10, 0, 0, 2, 1, 32'hDEADBEEF, 0);

    // Reset during the second byte of a split SH.
    req_valid = 1; req_load = 0; req_store = 1;
    req_funct3 = 3'b001; req_addr = 32'h16;
    req_wdata = 32'h5678; req_rd = 0;
    @(posedge clk); #1;
    req_valid = 0; req_store = 0;
    @(posedge clk); #1;
    chk("acc2_write", 32'(mem_write), 1);
    chk("acc2_addr", 32'(mem_addr), 32'h17);
    rst_n = 0;
    #1;
    chk_reset_outs();
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;
    chk_reset_outs();
    refm[9'h16] = 8'h78;
    chk("byte16", 32'(dmem[9'h16]), 32'h78);
    chk("byte17", 32'(dmem[9'h17]), 32'h12);
    xact(1, 0, 3'b010, 32'h14, 0, 3, 2, 1, 32'h12780000, 0);

    nbad = 0;
    for (int i = 0; i < 512; i++)
      if (dmem[i] !== refm[i]) nbad++;
    chk("mem_image", nbad, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
